// File: rtl/jtag_pp_pkg.sv
// Shared constants for the JTAG/DMA ping-pong buffer: default geometry and FSM state encoding.
package jtag_pp_pkg;

  localparam int PP_ADDR_W = 9;
  localparam int PP_DATA_W = 32;
  localparam int PP_DEPTH  = 512;

  localparam logic [1:0] PP_IDLE    = 2'd0;
  localparam logic [1:0] PP_PENDING = 2'd1;
  localparam logic [1:0] PP_SWAP    = 2'd2;

endpackage

// File: rtl/pp_bank_ram.sv
// Single-port synchronous RAM bank with registered read (old data on read-during-write).
// With PP_PARITY_EN defined each word carries an even-parity bit that is checked on read.
module pp_bank_ram
  import jtag_pp_pkg::*;
#(
  parameter int ADDR_W = PP_ADDR_W,
  parameter int DATA_W = PP_DATA_W
) (
  input  logic              clock,
  input  logic              n_reset,
  input  logic              write_enable,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              parity_err
);

`ifdef PP_PARITY_EN
  logic [DATA_W:0] mem [2**ADDR_W];
  logic [DATA_W:0] rd_word;

  assign rd_word = mem[address];

  always_ff @(posedge clock) begin
    if (write_enable) mem[address] <= {^data_in, data_in};
  end

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      data_out   <= '0;
      parity_err <= 1'b0;
    end else begin
      data_out   <= rd_word[DATA_W-1:0];
      parity_err <= rd_word[DATA_W] != (^rd_word[DATA_W-1:0]);
    end
  end
`else
  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clock) begin
    if (write_enable) mem[address] <= data_in;
  end

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) data_out <= '0;
    else          data_out <= mem[address];
  end

  assign parity_err = 1'b0;
`endif

endmodule

// File: rtl/jtag_pingpong_buffer.sv
// Double-banked buffer between JTAG and DMA; a bank exchange waits until the DMA is idle.
// Optional PP_PARITY_EN adds a parity bit per word and *_parity_err outputs.
module jtag_pingpong_buffer
  import jtag_pp_pkg::*;
#(
  parameter int ADDR_W = PP_ADDR_W,
  parameter int DATA_W = PP_DATA_W
) (
  input  logic              clock,
  input  logic              n_reset,
  input  logic [ADDR_W-1:0] dma_address,
  input  logic [DATA_W-1:0] dma_dataIn,
  input  logic              dma_writeEnable,
  output logic [DATA_W-1:0] dma_dataOut,
  input  logic [ADDR_W-1:0] jtag_address,
  input  logic [DATA_W-1:0] jtag_dataIn,
  input  logic              jtag_writeEnable,
  output logic [DATA_W-1:0] jtag_dataOut,
  input  logic              switch_request,
  input  logic              dma_busy,
  output logic              switch_pending,
  output logic              switch_done,
  output logic              active_bank,
  output logic [ADDR_W:0]   dma_fill,
  output logic [ADDR_W:0]   jtag_fill,
  output logic              dma_parity_err,
  output logic              jtag_parity_err
);

  localparam logic [ADDR_W:0] FILL_MAX = {1'b1, {ADDR_W{1'b0}}};

  logic [1:0]        state, state_next;
  logic              dma_sel_q;
  logic [ADDR_W-1:0] b0_addr, b1_addr;
  logic [DATA_W-1:0] b0_din, b1_din, b0_dout, b1_dout;
  logic              b0_we, b1_we, b0_perr, b1_perr;

  // Bank 0 belongs to DMA when active_bank is 0, bank 1 gets the other port.
  assign b0_addr = active_bank ? jtag_address     : dma_address;
  assign b0_din  = active_bank ? jtag_dataIn      : dma_dataIn;
  assign b0_we   = active_bank ? jtag_writeEnable : dma_writeEnable;
  assign b1_addr = active_bank ? dma_address      : jtag_address;
  assign b1_din  = active_bank ? dma_dataIn       : jtag_dataIn;
  assign b1_we   = active_bank ? dma_writeEnable  : jtag_writeEnable;

  pp_bank_ram #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_bank0 (
    .clock(clock), .n_reset(n_reset), .write_enable(b0_we), .address(b0_addr),
    .data_in(b0_din), .data_out(b0_dout), .parity_err(b0_perr)
  );

  pp_bank_ram #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_bank1 (
    .clock(clock), .n_reset(n_reset), .write_enable(b1_we), .address(b1_addr),
    .data_in(b1_din), .data_out(b1_dout), .parity_err(b1_perr)
  );

  // Read data was fetched under last cycle's mapping, so steer it with a delayed copy.
  assign dma_dataOut     = dma_sel_q ? b1_dout : b0_dout;
  assign jtag_dataOut    = dma_sel_q ? b0_dout : b1_dout;
  assign dma_parity_err  = dma_sel_q ? b1_perr : b0_perr;
  assign jtag_parity_err = dma_sel_q ? b0_perr : b1_perr;

  always_comb begin
    state_next = state;
    case (state)
      PP_IDLE:    if (switch_request) state_next = dma_busy ? PP_PENDING : PP_SWAP;
      PP_PENDING: if (!dma_busy)      state_next = PP_SWAP;
      PP_SWAP:                        state_next = PP_IDLE;
      default:                        state_next = PP_IDLE;
    endcase
  end

  assign switch_pending = (state == PP_PENDING);

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      state       <= PP_IDLE;
      active_bank <= 1'b0;
      dma_sel_q   <= 1'b0;
      switch_done <= 1'b0;
    end else begin
      state       <= state_next;
      dma_sel_q   <= active_bank;
      switch_done <= (state == PP_SWAP);
      if (state == PP_SWAP) active_bank <= ~active_bank;
    end
  end

  // A write landing in the SWAP cycle is discarded from the count: the clear wins.
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      dma_fill  <= '0;
      jtag_fill <= '0;
    end else if (state == PP_SWAP) begin
      dma_fill  <= '0;
      jtag_fill <= '0;
    end else begin
      if (dma_writeEnable && dma_fill != FILL_MAX)   dma_fill  <= dma_fill + 1'b1;
      if (jtag_writeEnable && jtag_fill != FILL_MAX) jtag_fill <= jtag_fill + 1'b1;
    end
  end

endmodule

// File: tb/tb_jtag_pingpong_buffer.sv
// Directed testbench for jtag_pingpong_buffer: vector table plus hand-written switch sequences.
// Build with PP_PARITY_EN defined to exercise the parity-error path.
module tb_jtag_pingpong_buffer;

  logic        clock = 1'b0;
  logic        n_reset;
  logic [8:0]  dma_address, jtag_address;
  logic [31:0] dma_dataIn, jtag_dataIn, dma_dataOut, jtag_dataOut;
  logic        dma_writeEnable, jtag_writeEnable;
  logic        switch_request, dma_busy;
  logic        switch_pending, switch_done, active_bank;
  logic [9:0]  dma_fill, jtag_fill;
  logic        dma_parity_err, jtag_parity_err;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct {
    logic        dma_we;
    logic [8:0]  dma_addr;
    logic [31:0] dma_din;
    logic        jtag_we;
    logic [8:0]  jtag_addr;
    logic [31:0] jtag_din;
    logic        chk_dma;
    logic [31:0] exp_dma;
    logic        chk_jtag;
    logic [31:0] exp_jtag;
    logic [9:0]  exp_dma_fill;
    logic [9:0]  exp_jtag_fill;
  } vec_t;

  vec_t vecs[8];

  jtag_pingpong_buffer u_dut (
    .clock(clock), .n_reset(n_reset),
    .dma_address(dma_address), .dma_dataIn(dma_dataIn), .dma_writeEnable(dma_writeEnable),
    .dma_dataOut(dma_dataOut),
    .jtag_address(jtag_address), .jtag_dataIn(jtag_dataIn), .jtag_writeEnable(jtag_writeEnable),
    .jtag_dataOut(jtag_dataOut),
    .switch_request(switch_request), .dma_busy(dma_busy),
    .switch_pending(switch_pending), .switch_done(switch_done), .active_bank(active_bank),
    .dma_fill(dma_fill), .jtag_fill(jtag_fill),
    .dma_parity_err(dma_parity_err), .jtag_parity_err(jtag_parity_err)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic dwe, input logic [8:0] da, input logic [31:0] dd,
                               input logic jwe, input logic [8:0] ja, input logic [31:0] jd);
    dma_writeEnable  = dwe;
    dma_address      = da;
    dma_dataIn       = dd;
    jtag_writeEnable = jwe;
    jtag_address     = ja;
    jtag_dataIn      = jd;
  endtask

  // Inputs change on the falling edge; outputs are sampled on the next falling edge.
  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic doSwitch(input logic exp_bank);
    switch_request = 1'b1;
    dma_busy = 1'b0;
    tick();
    switch_request = 1'b0;
    tick();
    checkOutput("switch_done_after_swap", {31'd0, switch_done}, 32'd1);
    checkOutput("active_bank_after_swap", {31'd0, active_bank}, {31'd0, exp_bank});
  endtask

  initial begin
    int done_count;
    int toggle_count;
    logic prev_bank;

    vecs[0] = '{1'b0, 9'd0, 32'd0, 1'b1, 9'd0, 32'hA5A50000, 1'b0, 32'd0, 1'b0, 32'd0, 10'd0, 10'd1};
    vecs[1] = '{1'b0, 9'd0, 32'd0, 1'b1, 9'd1, 32'hA5A50001, 1'b0, 32'd0, 1'b0, 32'd0, 10'd0, 10'd2};
    vecs[2] = '{1'b0, 9'd0, 32'd0, 1'b1, 9'd2, 32'hA5A50002, 1'b0, 32'd0, 1'b0, 32'd0, 10'd0, 10'd3};
    vecs[3] = '{1'b0, 9'd0, 32'd0, 1'b1, 9'd3, 32'hA5A50003, 1'b0, 32'd0, 1'b0, 32'd0, 10'd0, 10'd4};
    vecs[4] = '{1'b1, 9'd3, 32'hDEAD0003, 1'b0, 9'd1, 32'd0, 1'b0, 32'd0, 1'b1, 32'hA5A50001, 10'd1, 10'd4};
    vecs[5] = '{1'b0, 9'd3, 32'd0, 1'b0, 9'd3, 32'd0, 1'b1, 32'hDEAD0003, 1'b1, 32'hA5A50003, 10'd1, 10'd4};
    vecs[6] = '{1'b0, 9'd3, 32'd0, 1'b1, 9'd3, 32'h12345678, 1'b1, 32'hDEAD0003, 1'b1, 32'hA5A50003, 10'd1, 10'd5};
    vecs[7] = '{1'b0, 9'd0, 32'd0, 1'b0, 9'd3, 32'd0, 1'b0, 32'd0, 1'b1, 32'h12345678, 10'd1, 10'd5};

    n_reset = 1'b0;
    switch_request = 1'b0;
    dma_busy = 1'b0;
    applyStimulus(1'b0, 9'd0, 32'd0, 1'b0, 9'd0, 32'd0);
    repeat (3) @(negedge clock);
    checkOutput("reset_dma_dataOut", dma_dataOut, 32'd0);
    checkOutput("reset_jtag_dataOut", jtag_dataOut, 32'd0);
    checkOutput("reset_flags", {27'd0, switch_pending, switch_done, active_bank, dma_parity_err, jtag_parity_err}, 32'd0);
    checkOutput("reset_fills", {12'd0, dma_fill, jtag_fill}, 32'd0);
    n_reset = 1'b1;
    @(negedge clock);

    // Vector table: fill, read-back, read-during-write returns old data
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].dma_we, vecs[i].dma_addr, vecs[i].dma_din,
                    vecs[i].jtag_we, vecs[i].jtag_addr, vecs[i].jtag_din);
      tick();
      if (vecs[i].chk_dma)  checkOutput($sformatf("vec%0d_dma_dataOut", i), dma_dataOut, vecs[i].exp_dma);
      if (vecs[i].chk_jtag) checkOutput($sformatf("vec%0d_jtag_dataOut", i), jtag_dataOut, vecs[i].exp_jtag);
      checkOutput($sformatf("vec%0d_dma_fill", i), {22'd0, dma_fill}, {22'd0, vecs[i].exp_dma_fill});
      checkOutput($sformatf("vec%0d_jtag_fill", i), {22'd0, jtag_fill}, {22'd0, vecs[i].exp_jtag_fill});
      checkOutput($sformatf("vec%0d_parity", i), {30'd0, dma_parity_err, jtag_parity_err}, 32'd0);
    end
    applyStimulus(1'b0, 9'd0, 32'd0, 1'b0, 9'd0, 32'd0);

    // Test 1: immediate switch, done two edges after the request
    switch_request = 1'b1;
    tick();
    switch_request = 1'b0;
    checkOutput("t1_done_in_swap", {31'd0, switch_done}, 32'd0);
    checkOutput("t1_bank_in_swap", {31'd0, active_bank}, 32'd0);
    tick();
    checkOutput("t1_done", {31'd0, switch_done}, 32'd1);
    checkOutput("t1_bank", {31'd0, active_bank}, 32'd1);
    checkOutput("t1_fills_cleared", {12'd0, dma_fill, jtag_fill}, 32'd0);
    applyStimulus(1'b0, 9'd2, 32'd0, 1'b0, 9'd3, 32'd0);
    tick();
    checkOutput("t1_dma_read", dma_dataOut, 32'hA5A50002);
    checkOutput("t1_jtag_read", jtag_dataOut, 32'hDEAD0003);
    checkOutput("t1_done_pulse_end", {31'd0, switch_done}, 32'd0);

    // Test 2: deferred switch held off by dma_busy
    dma_busy = 1'b1;
    switch_request = 1'b1;
    tick();
    switch_request = 1'b0;
    for (int i = 0; i < 20; i++) begin
      checkOutput($sformatf("t2_hold%0d", i), {29'd0, switch_pending, switch_done, active_bank}, 32'b101);
      tick();
    end
    dma_busy = 1'b0;
    tick();
    checkOutput("t2_swap_cycle", {29'd0, switch_pending, switch_done, active_bank}, 32'b001);
    tick();
    checkOutput("t2_done", {29'd0, switch_pending, switch_done, active_bank}, 32'b010);

    // Test 3: second request while pending is ignored
    dma_busy = 1'b1;
    switch_request = 1'b1;
    tick();
    switch_request = 1'b0;
    tick();
    switch_request = 1'b1;
    tick();
    switch_request = 1'b0;
    repeat (3) tick();
    checkOutput("t3_pending", {30'd0, switch_pending, active_bank}, 32'b10);
    dma_busy = 1'b0;
    done_count = 0;
    toggle_count = 0;
    prev_bank = active_bank;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (switch_done) done_count++;
      if (active_bank != prev_bank) toggle_count++;
      prev_bank = active_bank;
    end
    checkOutput("t3_done_count", done_count, 32'd1);
    checkOutput("t3_toggle_count", toggle_count, 32'd1);
    checkOutput("t3_bank", {31'd0, active_bank}, 32'd1);

    // Test 4: simultaneous writes to the top address on both ports
    applyStimulus(1'b1, 9'h1FF, 32'h11111111, 1'b1, 9'h1FF, 32'h22222222);
    tick();
    applyStimulus(1'b0, 9'h1FF, 32'd0, 1'b0, 9'h1FF, 32'd0);
    doSwitch(1'b0);
    tick();
    checkOutput("t4_dma_read", dma_dataOut, 32'h22222222);
    checkOutput("t4_jtag_read", jtag_dataOut, 32'h11111111);

    // Test 5: fill saturation and a write in the SWAP cycle
    for (int i = 0; i < 600; i++) begin
      applyStimulus(1'b1, i[8:0], 32'hC0DE0000 | i, 1'b0, 9'd0, 32'd0);
      tick();
      if (i == 510) checkOutput("t5_fill_511", {22'd0, dma_fill}, 32'd511);
      if (i == 511) checkOutput("t5_fill_512", {22'd0, dma_fill}, 32'd512);
    end
    checkOutput("t5_fill_sat", {22'd0, dma_fill}, 32'd512);
    applyStimulus(1'b1, 9'd7, 32'h70000007, 1'b1, 9'd9, 32'h90000009);
    switch_request = 1'b1;
    tick();
    switch_request = 1'b0;
    checkOutput("t5_fill_in_swap", {12'd0, dma_fill, jtag_fill}, {12'd0, 10'd512, 10'd1});
    applyStimulus(1'b1, 9'd7, 32'h77777777, 1'b1, 9'd9, 32'h99999999);
    tick();
    checkOutput("t5_fill_cleared", {12'd0, dma_fill, jtag_fill}, 32'd0);
    checkOutput("t5_bank", {30'd0, switch_done, active_bank}, 32'b11);
    applyStimulus(1'b0, 9'd9, 32'd0, 1'b0, 9'd7, 32'd0);
    tick();
    checkOutput("t5_jtag_old_map_write", jtag_dataOut, 32'h77777777);
    checkOutput("t5_dma_old_map_write", dma_dataOut, 32'h99999999);
    checkOutput("t5_fills_idle", {12'd0, dma_fill, jtag_fill}, 32'd0);

    // Mid-operation reset drops a pending switch
    dma_busy = 1'b1;
    switch_request = 1'b1;
    tick();
    switch_request = 1'b0;
    checkOutput("rst_pending_before", {30'd0, switch_pending, active_bank}, 32'b11);
    n_reset = 1'b0;
    #1;
    checkOutput("rst_async", {29'd0, switch_pending, switch_done, active_bank}, 32'd0);
    @(negedge clock);
    n_reset = 1'b1;
    dma_busy = 1'b0;
    done_count = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (switch_done || active_bank || switch_pending) done_count++;
    end
    checkOutput("rst_dropped", done_count, 32'd0);

    // Test 6: parity
`ifdef PP_PARITY_EN
    applyStimulus(1'b1, 9'd5, 32'h0000_00F5, 1'b0, 9'd0, 32'd0);
    tick();
    applyStimulus(1'b1, 9'd6, 32'h0000_00F6, 1'b0, 9'd0, 32'd0);
    tick();
    u_dut.u_bank0.mem[5] = u_dut.u_bank0.mem[5] ^ 33'd1;
    applyStimulus(1'b0, 9'd5, 32'd0, 1'b0, 9'd0, 32'd0);
    tick();
    checkOutput("t6_parity_err", {31'd0, dma_parity_err}, 32'd1);
    applyStimulus(1'b0, 9'd6, 32'd0, 1'b0, 9'd0, 32'd0);
    tick();
    checkOutput("t6_parity_clear", {31'd0, dma_parity_err}, 32'd0);
    checkOutput("t6_good_data", dma_dataOut, 32'h0000_00F6);
`else
    for (int i = 0; i < 6; i++) begin
      applyStimulus(i[0], i[8:0], 32'h5A5A0000 | i, ~i[0], i[8:0], 32'h3C3C0000 | i);
      tick();
      checkOutput($sformatf("t6_parity_off%0d", i), {30'd0, dma_parity_err, jtag_parity_err}, 32'd0);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
